// File: rtl/l3_data_array_banked_if.sv
// Request/response bundle for the banked L3 data array.
// The master drives requests; the slave (the array) returns readiness and read data.
interface l3_data_array_banked_if #(
  parameter int WAYS        = 16,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 512,
  parameter int ID_WIDTH    = 4
);
  localparam int WAY_W = $clog2(WAYS);

  logic                      rd_req_valid;
  logic                      rd_req_ready;
  logic [INDEX_WIDTH-1:0]    rd_req_index;
  logic [WAY_W-1:0]          rd_req_way;
  logic [ID_WIDTH-1:0]       rd_req_id;

  logic                      wr_req_valid;
  logic                      wr_req_ready;
  logic [INDEX_WIDTH-1:0]    wr_req_index;
  logic [WAY_W-1:0]          wr_req_way;
  logic [DATA_WIDTH-1:0]     wr_req_data;
  logic [DATA_WIDTH/8-1:0]   wr_req_mask;

  logic                      rd_rsp_valid;
  logic [ID_WIDTH-1:0]       rd_rsp_id;
  logic [DATA_WIDTH-1:0]     rd_rsp_data;
  logic [DATA_WIDTH/64-1:0]  rd_rsp_perr;
  logic [15:0]               conflict_cnt;

  modport master (
    output rd_req_valid, rd_req_index, rd_req_way, rd_req_id,
    output wr_req_valid, wr_req_index, wr_req_way, wr_req_data, wr_req_mask,
    input  rd_req_ready, wr_req_ready,
    input  rd_rsp_valid, rd_rsp_id, rd_rsp_data, rd_rsp_perr, conflict_cnt
  );

  modport slave (
    input  rd_req_valid, rd_req_index, rd_req_way, rd_req_id,
    input  wr_req_valid, wr_req_index, wr_req_way, wr_req_data, wr_req_mask,
    output rd_req_ready, wr_req_ready,
    output rd_rsp_valid, rd_rsp_id, rd_rsp_data, rd_rsp_perr, conflict_cnt
  );
endinterface

// File: rtl/l3_data_array_banked.sv
// Banked L3 data array: one read and one write port, same-bank arbitration with
// read starvation protection, fixed-latency tagged reads. Optional: L3_DATA_PARITY_EN.
module l3_data_array_banked #(
  parameter int WAYS         = 16,
  parameter int INDEX_WIDTH  = 12,
  parameter int DATA_WIDTH   = 512,
  parameter int BANKS        = 4,
  parameter int READ_LAT     = 2,
  parameter int ID_WIDTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  l3_data_array_banked_if.slave bus
);
  localparam int WAY_W     = $clog2(WAYS);
  localparam int BANK_BITS = $clog2(BANKS);
  localparam int ROW_W     = INDEX_WIDTH - BANK_BITS + WAY_W;
  localparam int ROWS      = 2 ** ROW_W;
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int WORDS     = DATA_WIDTH / 64;
  localparam int SC_W      = $clog2(STARVE_LIMIT + 1);

  // Handshake: a request transfers on the edge where valid && ready. Request fields
  // hold while valid && !ready. Each ready looks only at the other port's valid.
  logic [BANK_BITS-1:0] w_rd_bank;
  logic [BANK_BITS-1:0] w_wr_bank;
  logic [ROW_W-1:0]     w_rd_row;
  logic [ROW_W-1:0]     w_wr_row;
  logic                 w_same_bank;
  logic                 w_starved;
  logic                 w_collision;
  logic                 w_rd_fire;
  logic                 w_wr_fire;

  logic [SC_W-1:0]      r_starve_cnt;
  logic [15:0]          r_conflict_cnt;

  assign w_rd_bank   = bus.rd_req_index[BANK_BITS-1:0];
  assign w_wr_bank   = bus.wr_req_index[BANK_BITS-1:0];
  assign w_rd_row    = {bus.rd_req_index[INDEX_WIDTH-1:BANK_BITS], bus.rd_req_way};
  assign w_wr_row    = {bus.wr_req_index[INDEX_WIDTH-1:BANK_BITS], bus.wr_req_way};
  assign w_same_bank = (w_rd_bank == w_wr_bank);
  assign w_starved   = (r_starve_cnt >= SC_W'(STARVE_LIMIT));
  assign w_collision = bus.rd_req_valid && bus.wr_req_valid && w_same_bank;

  assign bus.rd_req_ready = !(bus.wr_req_valid && w_same_bank && !w_starved);
  assign bus.wr_req_ready = !(bus.rd_req_valid && w_same_bank && w_starved);

  assign w_rd_fire = bus.rd_req_valid && bus.rd_req_ready;
  assign w_wr_fire = bus.wr_req_valid && bus.wr_req_ready;

  // A starved collision is exactly a read fire, so the counter never passes the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_rd_fire) begin
        r_starve_cnt <= '0;
      end else if (w_collision) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
      if (w_collision && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  assign bus.conflict_cnt = r_conflict_cnt;

  logic [BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;
`ifdef L3_DATA_PARITY_EN
  logic [BANKS-1:0][BYTES-1:0]      w_bank_rpar;
`endif

  // Each bank is a single-ported array with a registered read output.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [ROWS];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_we;
    logic                  w_re;

    assign w_we = w_wr_fire && (w_wr_bank == BANK_BITS'(b));
    assign w_re = w_rd_fire && (w_rd_bank == BANK_BITS'(b));

    always_ff @(posedge clk) begin
      if (w_we) begin
        for (int i = 0; i < BYTES; i++) begin
          if (bus.wr_req_mask[i]) begin
            r_mem[w_wr_row][i*8 +: 8] <= bus.wr_req_data[i*8 +: 8];
          end
        end
      end
      if (w_re) begin
        r_rdata <= r_mem[w_rd_row];
      end
    end

    assign w_bank_rdata[b] = r_rdata;

`ifdef L3_DATA_PARITY_EN
    logic [BYTES-1:0] r_par [ROWS];
    logic [BYTES-1:0] r_rpar;

    always_ff @(posedge clk) begin
      if (w_we) begin
        for (int i = 0; i < BYTES; i++) begin
          if (bus.wr_req_mask[i]) begin
            r_par[w_wr_row][i] <= ^bus.wr_req_data[i*8 +: 8];
          end
        end
      end
      if (w_re) begin
        r_rpar <= r_par[w_rd_row];
      end
    end

    assign w_bank_rpar[b] = r_rpar;
`endif
  end

  logic                  r_s1_valid;
  logic [ID_WIDTH-1:0]   r_s1_id;
  logic [BANK_BITS-1:0]  r_s1_bank;
  logic [DATA_WIDTH-1:0] w_s1_data;
  logic [WORDS-1:0]      w_s1_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_bank  <= '0;
    end else begin
      r_s1_valid <= w_rd_fire;
      r_s1_id    <= w_rd_fire ? bus.rd_req_id : '0;
      if (w_rd_fire) begin
        r_s1_bank <= w_rd_bank;
      end
    end
  end

  // Bank read registers are not reset, so data is gated to zero when no read is in flight.
  assign w_s1_data = r_s1_valid ? w_bank_rdata[r_s1_bank] : '0;

`ifdef L3_DATA_PARITY_EN
  logic [BYTES-1:0] w_s1_rpar;
  assign w_s1_rpar = w_bank_rpar[r_s1_bank];

  always_comb begin
    w_s1_perr = '0;
    for (int w = 0; w < WORDS; w++) begin
      for (int k = 0; k < 8; k++) begin
        w_s1_perr[w] = w_s1_perr[w] |
                       ((^w_s1_data[(w*8+k)*8 +: 8]) ^ w_s1_rpar[w*8+k]);
      end
    end
    if (!r_s1_valid) begin
      w_s1_perr = '0;
    end
  end
`else
  assign w_s1_perr = '0;
`endif

  if (READ_LAT == 2) begin : g_lat2
    logic                  r_out_valid;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [WORDS-1:0]      r_out_perr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_id    <= '0;
        r_out_data  <= '0;
        r_out_perr  <= '0;
      end else begin
        r_out_valid <= r_s1_valid;
        r_out_id    <= r_s1_id;
        r_out_data  <= w_s1_data;
        r_out_perr  <= w_s1_perr;
      end
    end

    assign bus.rd_rsp_valid = r_out_valid;
    assign bus.rd_rsp_id    = r_out_id;
    assign bus.rd_rsp_data  = r_out_data;
    assign bus.rd_rsp_perr  = r_out_perr;
  end else begin : g_lat1
    assign bus.rd_rsp_valid = r_s1_valid;
    assign bus.rd_rsp_id    = r_s1_id;
    assign bus.rd_rsp_data  = w_s1_data;
    assign bus.rd_rsp_perr  = w_s1_perr;
  end

endmodule

// File: tb/tb_l3_data_array_banked.sv
// Directed bench for l3_data_array_banked: reset, masked writes, arbitration,
// parallel banks, read latency/ordering, mid-stream reset, optional parity.
module tb_l3_data_array_banked;
  localparam int WAYS         = 16;
  localparam int INDEX_WIDTH  = 12;
  localparam int DATA_WIDTH   = 512;
  localparam int BANKS        = 4;
  localparam int READ_LAT     = 2;
  localparam int ID_WIDTH     = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int BYTES        = DATA_WIDTH / 8;
  localparam int WORDS        = DATA_WIDTH / 64;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  l3_data_array_banked_if #(
    .WAYS(WAYS), .INDEX_WIDTH(INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus_if ();

  l3_data_array_banked #(
    .WAYS(WAYS), .INDEX_WIDTH(INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BANKS(BANKS),
    .READ_LAT(READ_LAT), .ID_WIDTH(ID_WIDTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [31:0] seed);
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < WORDS; i++) begin
      p[i*64 +: 64] = {seed ^ 32'(i * 3), ~seed + 32'(i)};
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.rd_req_valid = 1'b0;
    bus_if.rd_req_index = '0;
    bus_if.rd_req_way   = '0;
    bus_if.rd_req_id    = '0;
    bus_if.wr_req_valid = 1'b0;
    bus_if.wr_req_index = '0;
    bus_if.wr_req_way   = '0;
    bus_if.wr_req_data  = '0;
    bus_if.wr_req_mask  = '0;
  endtask

  task automatic do_write(input logic [11:0] idx, input logic [3:0] way,
                          input logic [DATA_WIDTH-1:0] data, input logic [BYTES-1:0] mask);
    bus_if.wr_req_index = idx;
    bus_if.wr_req_way   = way;
    bus_if.wr_req_data  = data;
    bus_if.wr_req_mask  = mask;
    bus_if.wr_req_valid = 1'b1;
    #1;
    check("wr_ready", DATA_WIDTH'(bus_if.wr_req_ready), DATA_WIDTH'(1));
    tick();
    bus_if.wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] idx, input logic [3:0] way, input logic [3:0] id);
    bus_if.rd_req_index = idx;
    bus_if.rd_req_way   = way;
    bus_if.rd_req_id    = id;
    bus_if.rd_req_valid = 1'b1;
    #1;
    check("rd_ready", DATA_WIDTH'(bus_if.rd_req_ready), DATA_WIDTH'(1));
    tick();
    bus_if.rd_req_valid = 1'b0;
  endtask

  // Called just after the accept edge; the response must appear exactly READ_LAT cycles later.
  task automatic expect_rsp(input string tag, input logic [3:0] id,
                            input logic [DATA_WIDTH-1:0] data, input logic [WORDS-1:0] perr);
    check({tag, "_early"}, DATA_WIDTH'(bus_if.rd_rsp_valid), '0);
    tick();
    check({tag, "_valid"}, DATA_WIDTH'(bus_if.rd_rsp_valid), DATA_WIDTH'(1));
    check({tag, "_id"},    DATA_WIDTH'(bus_if.rd_rsp_id), DATA_WIDTH'(id));
    check({tag, "_data"},  bus_if.rd_rsp_data, data);
    check({tag, "_perr"},  DATA_WIDTH'(bus_if.rd_rsp_perr), DATA_WIDTH'(perr));
    tick();
    check({tag, "_pulse"}, DATA_WIDTH'(bus_if.rd_rsp_valid), '0);
  endtask

  logic [DATA_WIDTH-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, exp_m, ones;

  initial begin
    pat_a = pat(32'hA5A5_0001);
    pat_b = pat(32'h1234_5678);
    pat_c = pat(32'hC0DE_0C0C);
    pat_d = pat(32'hDEAD_BEEF);
    pat_e = pat(32'h0F0F_E0E0);
    ones  = {BYTES{8'hFF}};
    exp_m = '0;
    exp_m[7:0] = 8'hFF;

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check("rst_rsp_valid", DATA_WIDTH'(bus_if.rd_rsp_valid), '0);
    check("rst_rsp_id",    DATA_WIDTH'(bus_if.rd_rsp_id), '0);
    check("rst_rsp_data",  bus_if.rd_rsp_data, '0);
    check("rst_rsp_perr",  DATA_WIDTH'(bus_if.rd_rsp_perr), '0);
    check("rst_conflict",  DATA_WIDTH'(bus_if.conflict_cnt), '0);
    check("rst_starve",    DATA_WIDTH'(dut.r_starve_cnt), '0);
    rst_n = 1'b1;
    tick();

    // Basic write then read, latency 2
    do_write(12'h005, 4'd3, pat_a, '1);
    do_read(12'h005, 4'd3, 4'h7);
    expect_rsp("basic", 4'h7, pat_a, '0);

    // Byte masks, including an all-zero mask that must change nothing
    do_write(12'h010, 4'd0, ones, 64'h1);
    do_write(12'h010, 4'd0, '0, ~64'h1);
    do_read(12'h010, 4'd0, 4'h2);
    expect_rsp("mask", 4'h2, exp_m, '0);
    do_write(12'h010, 4'd0, {BYTES{8'h55}}, '0);
    do_read(12'h010, 4'd0, 4'h3);
    expect_rsp("mask0", 4'h3, exp_m, '0);

    // Same-bank contention on bank 1: write wins 4 times, read wins on the 5th
    do_write(12'h001, 4'd1, pat_b, '1);
    bus_if.wr_req_index = 12'h009;
    bus_if.wr_req_way   = 4'd0;
    bus_if.wr_req_data  = pat_c;
    bus_if.wr_req_mask  = '1;
    bus_if.wr_req_valid = 1'b1;
    bus_if.rd_req_index = 12'h001;
    bus_if.rd_req_way   = 4'd1;
    bus_if.rd_req_id    = 4'h4;
    bus_if.rd_req_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("cont_rd_ready", DATA_WIDTH'(bus_if.rd_req_ready), DATA_WIDTH'(k == 5));
      check("cont_wr_ready", DATA_WIDTH'(bus_if.wr_req_ready), DATA_WIDTH'(k != 5));
      check("cont_starve",   DATA_WIDTH'(dut.r_starve_cnt), DATA_WIDTH'(k - 1));
      tick();
    end
    bus_if.rd_req_valid = 1'b0;
    bus_if.wr_req_valid = 1'b0;
    check("cont_starve_clr", DATA_WIDTH'(dut.r_starve_cnt), '0);
    check("cont_conflict",   DATA_WIDTH'(bus_if.conflict_cnt), DATA_WIDTH'(5));
    expect_rsp("cont", 4'h4, pat_b, '0);

    // Different banks in the same cycle proceed in parallel
    do_write(12'h002, 4'd5, pat_c, '1);
    bus_if.rd_req_index = 12'h002;
    bus_if.rd_req_way   = 4'd5;
    bus_if.rd_req_id    = 4'h9;
    bus_if.rd_req_valid = 1'b1;
    bus_if.wr_req_index = 12'h003;
    bus_if.wr_req_way   = 4'd5;
    bus_if.wr_req_data  = pat_d;
    bus_if.wr_req_mask  = '1;
    bus_if.wr_req_valid = 1'b1;
    #1;
    check("par_rd_ready", DATA_WIDTH'(bus_if.rd_req_ready), DATA_WIDTH'(1));
    check("par_wr_ready", DATA_WIDTH'(bus_if.wr_req_ready), DATA_WIDTH'(1));
    tick();
    bus_if.rd_req_valid = 1'b0;
    bus_if.wr_req_valid = 1'b0;
    check("par_conflict", DATA_WIDTH'(bus_if.conflict_cnt), DATA_WIDTH'(5));
    expect_rsp("par_rd", 4'h9, pat_c, '0);
    do_read(12'h003, 4'd5, 4'hA);
    expect_rsp("par_wr", 4'hA, pat_d, '0);

    // Back-to-back reads return back-to-back, in order
    bus_if.rd_req_index = 12'h002;
    bus_if.rd_req_way   = 4'd5;
    bus_if.rd_req_id    = 4'hB;
    bus_if.rd_req_valid = 1'b1;
    tick();
    bus_if.rd_req_index = 12'h003;
    bus_if.rd_req_id    = 4'hC;
    tick();
    bus_if.rd_req_valid = 1'b0;
    check("b2b0_valid", DATA_WIDTH'(bus_if.rd_rsp_valid), DATA_WIDTH'(1));
    check("b2b0_id",    DATA_WIDTH'(bus_if.rd_rsp_id), DATA_WIDTH'(4'hB));
    check("b2b0_data",  bus_if.rd_rsp_data, pat_c);
    tick();
    check("b2b1_valid", DATA_WIDTH'(bus_if.rd_rsp_valid), DATA_WIDTH'(1));
    check("b2b1_id",    DATA_WIDTH'(bus_if.rd_rsp_id), DATA_WIDTH'(4'hC));
    check("b2b1_data",  bus_if.rd_rsp_data, pat_d);
    tick();
    check("b2b_end", DATA_WIDTH'(bus_if.rd_rsp_valid), '0);

    // Read right after a write returns the new data
    do_write(12'h005, 4'd3, pat_e, '1);
    do_read(12'h005, 4'd3, 4'hD);
    expect_rsp("raw", 4'hD, pat_e, '0);

`ifdef L3_DATA_PARITY_EN
    // Corrupt one stored bit in word 2 of index 0x020 way 0 (bank 0, row 128)
    do_write(12'h020, 4'd0, pat_a, '1);
    dut.g_bank[0].r_mem[128][131] = ~dut.g_bank[0].r_mem[128][131];
    exp_m = pat_a;
    exp_m[131] = ~exp_m[131];
    do_read(12'h020, 4'd0, 4'h5);
    expect_rsp("perr", 4'h5, exp_m, 8'b0000_0100);
`endif

    // Reset after the second of three back-to-back accepts drops all in-flight reads
    bus_if.rd_req_index = 12'h005;
    bus_if.rd_req_way   = 4'd3;
    bus_if.rd_req_id    = 4'h1;
    bus_if.rd_req_valid = 1'b1;
    tick();
    bus_if.rd_req_id = 4'h2;
    tick();
    bus_if.rd_req_id    = 4'h3;
    bus_if.rd_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_valid",    DATA_WIDTH'(bus_if.rd_rsp_valid), '0);
    check("mrst_id",       DATA_WIDTH'(bus_if.rd_rsp_id), '0);
    check("mrst_data",     bus_if.rd_rsp_data, '0);
    check("mrst_conflict", DATA_WIDTH'(bus_if.conflict_cnt), '0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("mrst_quiet", DATA_WIDTH'(bus_if.rd_rsp_valid), '0);
      check("mrst_quiet_data", bus_if.rd_rsp_data, '0);
      tick();
    end
    check("mrst_starve", DATA_WIDTH'(dut.r_starve_cnt), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
